// File: rtl/cpu_pkg.sv
// Shared constants for the CPU front end: default widths, reset vector and
// the all-zero bubble encoding inserted into the pipeline.
package cpu_pkg;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_RESET_PC   = 0;
    localparam logic [DEF_DATA_WIDTH-1:0] NOP_INSTR = '0;
endpackage

// File: rtl/ifid_register.sv
// IF/ID pipeline register: bubble load beats hold, hold beats a normal load.
// Bubbles still record the PC they replace so decode sees a coherent address.
module ifid_register
    import cpu_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_bubble,
    input  logic                  i_hold,
    input  logic [DATA_WIDTH-1:0] i_instr,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_plus1,
    output logic                  o_valid
);
    logic [DATA_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_pc_plus1;
    logic                  r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr    <= DATA_WIDTH'(NOP_INSTR);
            r_pc       <= RESET_PC;
            r_pc_plus1 <= RESET_PC + ADDR_WIDTH'(1);
            r_valid    <= 1'b0;
        end else if (i_bubble) begin
            r_instr    <= DATA_WIDTH'(NOP_INSTR);
            r_pc       <= i_pc;
            r_pc_plus1 <= i_pc + ADDR_WIDTH'(1);
            r_valid    <= 1'b0;
        end else if (!i_hold) begin
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus1 <= i_pc + ADDR_WIDTH'(1);
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus1 = r_pc_plus1;
    assign o_valid    = r_valid;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the synchronous instruction memory with
// pc_next so that imem_data always corresponds to pc_q after each edge.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [DATA_WIDTH-1:0] ifid_instr,
    output logic [ADDR_WIDTH-1:0] ifid_pc,
    output logic [ADDR_WIDTH-1:0] ifid_pc_plus1,
    output logic                  ifid_valid,
    output logic [31:0]           fetch_count
);
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_fvalid;
    logic [31:0]           r_fetch_count;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic                  w_bubble;
    logic                  w_load;

    always_comb begin
        w_pc_next = r_pc;
        if (!rst_n)
            w_pc_next = RESET_PC;
        else if (redirect)
            w_pc_next = redirect_target;
        else if (stall || !r_fvalid)
            w_pc_next = r_pc;
        else
            w_pc_next = r_pc + ADDR_WIDTH'(1);
    end

    // Memory latches the same address the PC takes: no alignment skew.
    assign imem_address = w_pc_next;

    // Untrusted data only bubbles when not stalled; a stall holds IF/ID instead.
    assign w_bubble = redirect | flush | (~stall & ~r_fvalid);
    assign w_load   = ~redirect & ~flush & ~stall & r_fvalid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_fvalid      <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_pc     <= w_pc_next;
            r_fvalid <= 1'b1;
            if (w_load)
                r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;

    ifid_register #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_ifid (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_bubble   (w_bubble),
        .i_hold     (stall),
        .i_instr    (imem_data),
        .i_pc       (r_pc),
        .o_instr    (ifid_instr),
        .o_pc       (ifid_pc),
        .o_pc_plus1 (ifid_pc_plus1),
        .o_valid    (ifid_valid)
    );
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random control traffic,
// with delivered IF/ID words checked against a program-order scoreboard.
module tb_instruction_fetch;
    localparam logic [9:0] RST_PC = 10'd0;

    logic        clk;
    logic        rst_n, stall, flush, redirect;
    logic [9:0]  redirect_target, imem_address;
    logic [31:0] imem_data, ifid_instr, fetch_count;
    logic [9:0]  ifid_pc, ifid_pc_plus1;
    logic        ifid_valid;

    logic [31:0] mem [1024];

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  pc;
        logic [9:0]  pc1;
    } exp_t;
    exp_t exp_q[$];

    int unsigned nvec  = 0;
    int unsigned nfail = 0;

    // Reference state: address whose word the memory presents, whether it is
    // trusted yet, and what IF/ID should currently contain.
    logic [9:0]  m_pc    = RST_PC;
    logic        m_trust = 1'b0;
    logic        m_ifv   = 1'b0;
    logic [9:0]  m_last  = '0;
    logic [31:0] m_cnt   = '0;
    logic [31:0] prev_cnt = '0;

    instruction_fetch #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .flush           (flush),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_address    (imem_address),
        .imem_data       (imem_data),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus1   (ifid_pc_plus1),
        .ifid_valid      (ifid_valid),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_address];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic st, input logic fl, input logic rd,
                              input logic [9:0] tgt, input logic rn);
        exp_t e;
        if (!rn) begin
            m_pc = RST_PC; m_trust = 1'b0; m_cnt = '0; m_ifv = 1'b0;
        end else begin
            if (rd) begin
                m_pc = tgt; m_ifv = 1'b0;
            end else if (fl) begin
                if (!st && m_trust) m_pc = m_pc + 10'd1;
                m_ifv = 1'b0;
            end else if (st) begin
                // IF/ID and PC both hold
            end else if (!m_trust) begin
                m_ifv = 1'b0;
            end else begin
                e.instr = mem[m_pc];
                e.pc    = m_pc;
                e.pc1   = m_pc + 10'd1;
                exp_q.push_back(e);
                m_cnt  = m_cnt + 32'd1;
                m_last = m_pc;
                m_ifv  = 1'b1;
                m_pc   = m_pc + 10'd1;
            end
            m_trust = 1'b1;
        end
    endtask

    task automatic cyc(input logic st, input logic fl, input logic rd,
                       input logic [9:0] tgt, input logic rn);
        stall = st; flush = fl; redirect = rd; redirect_target = tgt; rst_n = rn;
        @(posedge clk);
        model_edge(st, fl, rd, tgt, rn);
        @(negedge clk);
        #1;
        chk("valid", ifid_valid, m_ifv);
        chk("fetch_count", fetch_count, m_cnt);
        if (!m_ifv) chk("bubble_instr", ifid_instr, 32'd0);
    endtask

    task automatic run_to(input logic [9:0] p);
        for (int i = 0; i < 1100; i++) begin
            if (m_ifv && m_last == p) break;
            cyc(0, 0, 0, '0, 1);
        end
        chk("reach_pc", ifid_pc, 32'(p));
    endtask

    // Monitor: a new delivery is a valid IF/ID whose fetch_count advanced.
    always @(negedge clk) begin
        exp_t e;
        if (ifid_valid === 1'b1 && fetch_count !== prev_cnt) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_delivery", ifid_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr", ifid_instr, e.instr);
                chk("sb_pc", ifid_pc, 32'(e.pc));
                chk("sb_pc_plus1", ifid_pc_plus1, 32'(e.pc1));
            end
        end
        prev_cnt = fetch_count;
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + 32'(i);
        stall = 0; flush = 0; redirect = 0; redirect_target = '0; rst_n = 0;

        // 1: reset and free run
        cyc(0, 0, 0, '0, 0);
        cyc(0, 0, 0, '0, 0);
        chk("rst_pc", ifid_pc, 32'(RST_PC));
        chk("rst_pc_plus1", ifid_pc_plus1, 32'(RST_PC + 10'd1));
        cyc(0, 0, 0, '0, 1);
        chk("s1_first_bubble", ifid_valid, 0);
        cyc(0, 0, 0, '0, 1);
        chk("s1_first_instr", ifid_instr, 32'h1000);
        chk("s1_first_pc", ifid_pc, 0);
        cyc(0, 0, 0, '0, 1);
        cyc(0, 0, 0, '0, 1);
        chk("s1_instr3", ifid_instr, 32'h1002);
        chk("s1_count3", fetch_count, 3);

        // 2: stall while ifid_pc = 5
        run_to(10'd5);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, '0, 1);
            chk("s2_hold_instr", ifid_instr, 32'h1005);
            chk("s2_hold_pc", ifid_pc, 5);
            chk("s2_imem_addr", imem_address, 6);
        end
        cyc(0, 0, 0, '0, 1);
        chk("s2_resume_instr", ifid_instr, 32'h1006);
        chk("s2_resume_pc", ifid_pc, 6);

        // 3: redirect at ifid_pc = 7
        run_to(10'd7);
        cyc(0, 0, 1, 10'h200, 1);
        chk("s3_bubble_valid", ifid_valid, 0);
        chk("s3_count_held", fetch_count, 8);
        cyc(0, 0, 0, '0, 1);
        chk("s3_tgt_instr", ifid_instr, 32'h1200);
        chk("s3_tgt_pc", ifid_pc, 32'h200);
        chk("s3_tgt_pc_plus1", ifid_pc_plus1, 32'h201);
        chk("s3_count", fetch_count, 9);

        // 4: redirect wins over stall; flush with stall refetches
        cyc(1, 0, 1, 10'h300, 1);
        chk("s4_rd_stall_bubble", ifid_valid, 0);
        cyc(0, 0, 0, '0, 1);
        chk("s4_rd_stall_instr", ifid_instr, 32'h1300);
        cyc(0, 0, 1, 10'd9, 1);
        cyc(1, 1, 0, '0, 1);
        chk("s4_flush_bubble", ifid_valid, 0);
        cyc(0, 0, 0, '0, 1);
        chk("s4_refetch_instr", ifid_instr, 32'h1009);
        chk("s4_refetch_pc", ifid_pc, 9);

        // 5: PC wrap
        cyc(0, 0, 1, 10'd1020, 1);
        run_to(10'd1023);
        chk("s5_pc_plus1_wrap", ifid_pc_plus1, 0);
        cyc(0, 0, 0, '0, 1);
        chk("s5_wrap_pc", ifid_pc, 0);
        chk("s5_wrap_instr", ifid_instr, 32'h1000);

        // 6: reset mid-stream during a stall
        cyc(0, 0, 0, '0, 1);
        cyc(1, 0, 0, '0, 1);
        cyc(1, 0, 0, '0, 0);
        chk("s6_imem_addr", imem_address, 32'(RST_PC));
        chk("s6_instr", ifid_instr, 0);
        cyc(0, 0, 0, '0, 1);
        cyc(0, 0, 0, '0, 1);
        chk("s6_restart_instr", ifid_instr, 32'h1000);
        chk("s6_restart_count", fetch_count, 1);

        // Random phase with fresh memory contents loaded under reset
        cyc(0, 0, 0, '0, 0);
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 10),
                ($urandom_range(0, 99) < 8), 10'($urandom_range(0, 1023)),
                ($urandom_range(0, 199) != 0));
        end
        cyc(0, 0, 0, '0, 1);
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the synchronous-read instruction memory (1-cycle read latency, word-addressed, no enable).
- Owns the program counter and drives the memory address.
- Pairs each returned word with its PC and registers both into the IF/ID pipeline register consumed by decode.
- Handles stall, flush and branch/jump redirect.
- Inserts all-zero NOP bubbles, the codebase's bubble encoding.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 10, PC / memory word-address width
RESET_PC, 0, word address fetched first after reset

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
stall  in  1  hazard unit: hold PC and IF/ID contents
flush  in  1  squash the word currently entering IF/ID
redirect  in  1  taken branch/jump: load redirect_target
redirect_target  in  ADDR_WIDTH  new PC (word address)
imem_address  out  ADDR_WIDTH  to instruction memory address input (combinational = pc_next)
imem_data  in  DATA_WIDTH  from instruction memory registered output
ifid_instr  out  DATA_WIDTH  registered instruction to decode
ifid_pc  out  ADDR_WIDTH  address of ifid_instr
ifid_pc_plus1  out  ADDR_WIDTH  ifid_pc+1 mod 2^ADDR_WIDTH (link/branch base)
ifid_valid  out  1  ifid_instr is a real fetched instruction
fetch_count  out  32  number of valid instructions delivered to IF/ID

Behaviour:
- State: pc_q, fvalid_q (imem_data corresponds to pc_q), IF/ID regs, fetch_count.
- pc_next, priority order:
  - !rst_n -> RESET_PC
  - redirect -> redirect_target
  - stall or !fvalid_q -> pc_q
  - else pc_q+1, wrapping 2^ADDR_WIDTH-1 -> 0
- imem_address = pc_next combinationally. The memory latches the same address pc_q takes, so after every edge imem_data = mem[pc_q] (zero alignment skew).
- Stall: the same address is re-read, so imem_data stays stable.
- fvalid_q:
  - rst_n low -> 0
  - otherwise -> 1 on the next edge
  - First cycle after reset release: imem_data is not yet trusted; PC holds at RESET_PC.
- IF/ID update each edge, priority order:
  - !rst_n: instr=0, pc=RESET_PC, pc_plus1=RESET_PC+1, valid=0.
  - redirect (overrides stall): load bubble (instr=0, valid=0). pc/pc_plus1 take pc_q values.
  - flush: load bubble. PC follows the pc_next rule, so flush+stall holds PC and the word is refetched, not lost.
  - stall: all IF/ID regs hold.
  - !fvalid_q: load bubble.
  - else: instr=imem_data, pc=pc_q, pc_plus1=pc_q+1, valid=1.
- fetch_count:
  - Reset 0.
  - +1 on every edge where IF/ID loads valid=1.
  - Wraps at 2^32.
- Latency:
  - Reset release to first valid IF/ID = 2 edges (mem[RESET_PC]).
  - Redirect penalty = exactly 1 bubble; mem[target] appears in IF/ID on the 2nd edge after redirect.
- Reset mid-operation (rst_n low on any edge): all state returns to reset values that edge, regardless of stall/flush/redirect.
- Outputs and pc_q must never hold X after one reset edge.

Decomposition:
- Shared package (cpu_pkg):
  - NOP_INSTR = 0
  - DATA_WIDTH/ADDR_WIDTH defaults
  - RESET_PC
- One natural sub-module: ifid_register, the IF/ID register with stall-hold, bubble-load and valid bit.
- pc_next mux, pc_q, fvalid_q and fetch_count stay in instruction_fetch.

Test Plan:
1. Reset, then free-run with bench memory mem[i]=0x1000+i -> ifid_valid first high 2 edges after release with instr 0x1000, pc 0; then 0x1001, 0x1002... one per cycle; fetch_count=3 after three valid words.
2. stall high 3 cycles while ifid_pc=5 -> IF/ID holds 0x1005/pc 5; imem_address stays 6; after release 0x1006 follows with no gap or duplicate.
3. redirect with target 0x200 while ifid_pc=7 -> next IF/ID is bubble (instr 0, valid 0); following is instr mem[0x200], pc 0x200, pc_plus1 0x201; fetch_count skips the bubble.
4. redirect and stall same cycle -> redirect wins: bubble, then mem[target]; flush with stall at pc_q=9 -> bubble, then mem[9] delivered (not dropped).
5. Run PC to 1023 (ADDR_WIDTH=10) -> ifid_pc 1023, ifid_pc_plus1 0, next ifid_pc 0 with mem[0].
6. rst_n low for one edge mid-stream during a stall -> ifid_valid 0, instr 0, fetch_count 0, imem_address RESET_PC; normal restart per scenario 1.
